// File: rtl/sync_channel_scheduler.sv
// Round-robin scheduler sharing one multi-bit synchronizer channel between requesters.
// The granted word is held for HOLD_CYCLES source cycles, then a one-cycle ack goes back to its owner.
module sync_channel_scheduler #(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 12,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*WIDTH-1:0]      data_in,
  output logic [N_REQ-1:0]            ack,
  output logic [WIDTH-1:0]            tx_data,
  output logic [$clog2(N_REQ)-1:0]    tx_sel,
  output logic                        tx_tag,
  output logic                        busy
);

  localparam int SEL_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   last_q;
  logic [WIDTH-1:0]   tx_data_q;
  logic [SEL_W-1:0]   tx_sel_q;
  logic               tx_tag_q;
  logic [N_REQ-1:0]   ack_q;
  logic               busy_q;

  logic               grant_valid_d;
  logic [SEL_W-1:0]   grant_idx_d;
  logic [WIDTH-1:0]   grant_word_d;

  // Returns {valid, index} of the first request at or after last+1, wrapping modulo N_REQ.
  function automatic logic [SEL_W:0] arbitrate(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] cand;
    // NOTE: every variable gets a value before any conditional write, so no latch can be inferred.
    res  = '0;
    cand = '0;
    // Scan from the farthest offset down so the nearest pending requester is written last and wins.
    for (int off = N_REQ; off >= 1; off--) begin
      cand = SEL_W'((int'(last) + off) % N_REQ);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  always_comb begin
    {grant_valid_d, grant_idx_d} = arbitrate(req, last_q);
    grant_word_d                 = data_in[grant_idx_d*WIDTH +: WIDTH];
  end

  // NOTE: all state and outputs update with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_W'(N_REQ - 1);
      tx_data_q <= '0;
      tx_sel_q  <= '0;
      tx_tag_q  <= 1'b0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_d) begin
            tx_data_q <= grant_word_d;
            tx_sel_q  <= grant_idx_d;
            last_q    <= grant_idx_d;
            tx_tag_q  <= ~tx_tag_q;
            cnt_q     <= CNT_W'(HOLD_CYCLES - 1);
            busy_q    <= 1'b1;
            state_q   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Requests and data are deliberately ignored until the synchronizer has had its full hold time.
          if (cnt_q == '0) begin
            ack_q   <= N_REQ'(1) << tx_sel_q;
            state_q <= ST_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ACK: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack     = ack_q;
  assign tx_data = tx_data_q;
  assign tx_sel  = tx_sel_q;
  assign tx_tag  = tx_tag_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sync_channel_scheduler.sv
// Self-checking bench for sync_channel_scheduler: vector table of single transfers plus
// hand-written multi-cycle sequences, with a grant scoreboard fed at stimulus time.
module tb_sync_channel_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 12;
  localparam int HOLD  = 8;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       tx_data;
  logic [1:0]             tx_sel;
  logic                   tx_tag;
  logic                   busy;

  sync_channel_scheduler #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .ack(ack), .tx_data(tx_data), .tx_sel(tx_sel), .tx_tag(tx_tag), .busy(busy)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] data;
    int          cyc;
  } grant_t;

  typedef struct {
    logic [3:0]  req;
    logic [47:0] data;
    logic [1:0]  exp_sel;
    logic [11:0] exp_data;
  } vec_t;

  grant_t sb_q[$];
  vec_t   vecs[8];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic   prev_tag = 1'b0;
  logic   exp_tag = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor: every tx_tag toggle must match the oldest expected grant.
  always @(negedge clk) begin
    grant_t g;
    if (rst) begin
      prev_tag = 1'b0;
      exp_tag  = 1'b0;
    end else begin
      if (tx_tag !== prev_tag) begin
        prev_tag = tx_tag;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got sel %0d data %0h expected no grant (cycle %0d)",
                   tx_sel, tx_data, cyc);
        end else begin
          g = sb_q.pop_front();
          exp_tag = ~exp_tag;
          check("grant_tag", 64'(tx_tag), 64'(exp_tag));
          check("grant_sel", 64'(tx_sel), 64'(g.sel));
          check("grant_data", 64'(tx_data), 64'(g.data));
          check("grant_cycle", 64'(cyc), 64'(g.cyc));
        end
      end
      if (ack != '0) check("ack_onehot", 64'($onehot(ack)), 64'(1));
    end
  end

  task automatic wait_ack(input logic [1:0] sel, input int exp_cyc);
    int         n = 0;
    logic [3:0] e = 4'b0001 << sel;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 40);
    check("ack_value", 64'(ack), 64'(e));
    check("ack_cycle", 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int k;
    @(posedge clk);
    #1;
    req     = v.req;
    data_in = v.data;
    k       = cyc;
    sb_q.push_back('{v.exp_sel, v.exp_data, k + 1});
    @(negedge clk);
    check("vec_busy_pre", 64'(busy), 64'(0));
    @(negedge clk);
    check("vec_busy_grant", 64'(busy), 64'(1));
    wait_ack(v.exp_sel, k + HOLD + 1);
    check("vec_data_held", 64'(tx_data), 64'(v.exp_data));
    req = '0;
    @(negedge clk);
    check("vec_busy_post", 64'(busy), 64'(0));
  endtask

  initial begin
    int k;
    int r;
    logic [11:0] words[4];

    vecs[0] = '{4'b0001, 48'h000_000_000_A5C, 2'd0, 12'hA5C};
    vecs[1] = '{4'b1111, 48'h444_333_222_111, 2'd1, 12'h222};
    vecs[2] = '{4'b0101, 48'h000_C33_000_0F0, 2'd2, 12'hC33};
    vecs[3] = '{4'b0011, 48'h000_000_B0B_0D0, 2'd0, 12'h0D0};
    vecs[4] = '{4'b1000, 48'hE1E_000_000_000, 2'd3, 12'hE1E};
    vecs[5] = '{4'b1010, 48'h3C3_000_1C1_000, 2'd1, 12'h1C1};
    vecs[6] = '{4'b1001, 48'h9A9_000_000_090, 2'd3, 12'h9A9};
    vecs[7] = '{4'b0001, 48'h000_000_000_7FF, 2'd0, 12'h7FF};

    rst     = 1'b0;
    req     = '0;
    data_in = '0;
    do_reset();
    @(negedge clk);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_tx_sel", 64'(tx_sel), 64'(0));
    check("rst_tx_tag", 64'(tx_tag), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    // Long idle after the 7FF transfer: nothing may move.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_hold", {47'b0, ack, busy, tx_data}, {47'b0, 4'b0, 1'b0, 12'h7FF});
      check("idle_tag", 64'(tx_tag), 64'(exp_tag));
    end

    // Fairness: all requests held high from a fresh reset.
    do_reset();
    words = '{12'h111, 12'h222, 12'h333, 12'h444};
    @(posedge clk);
    #1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) data_in[i*WIDTH +: WIDTH] = words[i];
    k = cyc;
    for (int j = 0; j < 5; j++) sb_q.push_back('{2'(j % 4), words[j % 4], k + 1 + j * (HOLD + 2)});
    for (int j = 0; j < 5; j++) wait_ack(2'(j % 4), k + HOLD + 1 + j * (HOLD + 2));
    req = '0;

    // Request 1 arrives while requester 2 is holding.
    @(posedge clk);
    #1;
    data_in = '0;
    data_in[2*WIDTH +: WIDTH] = 12'hABC;
    req = 4'b0100;
    k = cyc;
    sb_q.push_back('{2'd2, 12'hABC, k + 1});
    sb_q.push_back('{2'd1, 12'h123, k + HOLD + 3});
    repeat (3) @(negedge clk);
    req[1] = 1'b1;
    data_in[1*WIDTH +: WIDTH] = 12'h123;
    for (int i = 0; i < HOLD - 2; i++) begin
      @(negedge clk);
      check("late_hold_data", 64'(tx_data), 64'(12'hABC));
    end
    wait_ack(2'd2, k + HOLD + 1);
    req[2] = 1'b0;
    wait_ack(2'd1, k + 2 * HOLD + 3);
    req = '0;

    // Granted requester withdraws and changes its word mid-hold.
    @(posedge clk);
    #1;
    data_in = '0;
    data_in[0 +: WIDTH] = 12'h5A5;
    req = 4'b0001;
    k = cyc;
    sb_q.push_back('{2'd0, 12'h5A5, k + 1});
    repeat (3) @(negedge clk);
    req = '0;
    data_in[0 +: WIDTH] = 12'hFFF;
    for (int i = 0; i < HOLD - 2; i++) begin
      @(negedge clk);
      check("drop_hold_data", 64'(tx_data), 64'(12'h5A5));
    end
    wait_ack(2'd0, k + HOLD + 1);

    // Reset during requester 3's hold abandons it; arbitration restarts at requester 0.
    @(posedge clk);
    #1;
    data_in = '0;
    data_in[3*WIDTH +: WIDTH] = 12'h777;
    req = 4'b1000;
    k = cyc;
    sb_q.push_back('{2'd3, 12'h777, k + 1});
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", {47'b0, ack, busy, tx_data}, 64'(0));
    check("arst_sel_tag", {61'b0, tx_sel, tx_tag}, 64'(0));
    req = 4'b1001;
    data_in[0 +: WIDTH] = 12'h0AA;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    r = cyc;
    sb_q.push_back('{2'd0, 12'h0AA, r + 1});
    sb_q.push_back('{2'd3, 12'h777, r + HOLD + 3});
    wait_ack(2'd0, r + HOLD + 1);
    req[0] = 1'b0;
    wait_ack(2'd3, r + 2 * HOLD + 3);
    req = '0;

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sync_channel_scheduler.md
# sync_channel_scheduler

Round-robin scheduler that shares the single 12-bit multi-bit synchronizer channel between several source-domain requesters, such as DDS waveform, LFSR and modulation words.
- It grants one requester at a time and drives the synchronizer's input with a registered word.
- It holds that word stable long enough for the 3-flop synchronizer to capture it without skew.
- It acknowledges each completed transfer back to its requester.
- It sits entirely in the source clock domain, directly upstream of the synchronizer's `sig` input.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2–8.
- `WIDTH`, default 12: data word width; must match the synchronizer width.
- `HOLD_CYCLES`, default 8: cycles each word is held before acknowledgement; legal range ≥4.
- `clk`  in  1: source-domain clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req`  in  N_REQ: per-requester transfer request; level, held until `ack`.
- `data_in`  in  N_REQ*WIDTH: packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- `ack`  out  N_REQ: one-cycle completion pulse to the granted requester.
- `tx_data`  out  WIDTH: word driven to the synchronizer input; registered.
- `tx_sel`  out  $clog2(N_REQ): index of the requester owning `tx_data`.
- `tx_tag`  out  1: toggles on every new grant so the destination can detect a new word.
- `busy`  out  1: high in HOLD and ACK.

## Operation
- State machine has three states: IDLE, HOLD and ACK.
- **IDLE**
  - If any `req` bit is high, grant the first requester at or after `last+1` in wrap-around order (mod N_REQ).
  - On the grant edge:
    - `tx_data` ← that requester's `data_in` slice.
    - `tx_sel` ← index.
    - `last` ← index.
    - `tx_tag` inverts.
    - `cnt` ← HOLD_CYCLES-1.
    - Next state is HOLD.
  - If no request is pending, all registers hold their values.
- **HOLD**
  - `cnt` decrements each cycle.
  - When `cnt`==0, next state is ACK and `ack[tx_sel]` is registered high.
  - `req` and `data_in` are ignored in HOLD.
  - Deassertion of the granted `req` does not abort the transfer; `ack` is still issued.
- **ACK**
  - Lasts exactly one cycle with `ack[tx_sel]`=1 and no arbitration.
  - Next state is IDLE and `ack` returns to 0.
  - The requester must drop `req` (or present a new word) by the edge ending the ACK cycle.
- `tx_data`, `tx_sel` and `tx_tag` change only on a grant edge. Between grants they retain the last value.
- `data_in` is sampled only at the grant edge. Requesters must keep their word stable from raising `req` until `ack`.
- At most one `ack` bit is high in any cycle. `ack` is never asserted to a non-granted requester.
- Fairness: with all requests held high, grants rotate 0,1,2,…,N_REQ-1,0,…
  - A requester waits at most (N_REQ-1) transfers.

## Timing
- Reset values:
  - All outputs are 0: `ack`, `tx_data`, `tx_sel`, `tx_tag`, `busy`.
  - State is IDLE, `cnt`=0 and `last`=N_REQ-1, so requester 0 has first priority.
- Grant latency: `req` high in IDLE at cycle k → `tx_data` valid and `busy`=1 from cycle k+1.
- Hold: `tx_data` is stable for cycles k+1 … k+HOLD_CYCLES.
- `ack` is high in cycle k+HOLD_CYCLES+1. IDLE resumes at k+HOLD_CYCLES+2, which is the earliest next grant edge.
- Minimum transfer period is HOLD_CYCLES+2 cycles: 10 with defaults.
- `busy` is high for HOLD_CYCLES+1 cycles per transfer.
- Reset mid-HOLD or mid-ACK:
  - The transfer is abandoned immediately (asynchronous) and no `ack` is issued.
  - Arbitration restarts from requester 0 on the first edge after `rst` falls.
- A request arriving in HOLD or ACK is not lost; it is arbitrated in the next IDLE cycle.

## Test plan
- Reset, then `req`=0001 with `data_in[11:0]`=12'hA5C at cycle 2:
  - `tx_data`=A5C, `tx_sel`=0, `tx_tag`=1 and `busy`=1 from cycle 3.
  - `ack`=0001 only in cycle 11.
  - `busy`=0 in cycle 12.
- All four `req` held high with words 111/222/333/444:
  - Grant order is 0,1,2,3,0 with grant edges spaced 10 cycles.
  - `tx_tag` alternates on each grant.
  - Exactly one `ack` bit is high per transfer.
- `req`=0100 active, and `req[1]` rises during its HOLD:
  - Requester 1 is granted on the first IDLE cycle after the ACK.
  - `tx_data` is unchanged during requester 2's hold.
- Granted requester drops `req` mid-HOLD and changes `data_in`:
  - `tx_data` keeps the originally sampled word.
  - `ack` is still pulsed at k+HOLD_CYCLES+1.
- `rst` asserted at HOLD cycle 3 while `req[3]` is granted:
  - All outputs are 0 within the same cycle and no `ack` is issued.
  - After release with `req`=1001, requester 0 is granted first.
- `req` idle for 50 cycles after a transfer of 7FF:
  - `tx_data` stays 7FF, `tx_tag` is constant, and `ack`=0 and `busy`=0 throughout.
